// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_mem_pkg
//  Purpose  : Shared definitions for the fetch/data memory port arbiter:
//             owner encodings, arbiter state encodings and default widths.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_mem_pkg;

  // Default bus widths (bytes-addressed, 32-bit word)
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Which requester owns the outstanding memory transaction
  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

  // Arbiter state encodings
  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage : cpu_mem_pkg
`default_nettype wire

// File: rtl/arb_select.sv
`default_nettype none
// ============================================================================
//  Module   : arb_select
//  Purpose  : Combinational winner selection between fetch and data.
//             Data wins by default; fetch wins once the data streak is full.
//  Ports    : if_req      in  fetch request (already qualified by issue window)
//             d_req       in  data request  (already qualified by issue window)
//             streak_full in  data has won MAX_DATA_STREAK times in a row
//             grant_if    out fetch wins this cycle
//             grant_d     out data wins this cycle
//  Revision : 1.0 - initial release
// ============================================================================
module arb_select (
  input  logic if_req,
  input  logic d_req,
  input  logic streak_full,
  output logic grant_if,
  output logic grant_d
);

  // Starvation override: a full streak with fetch waiting hands the slot to fetch.
  assign grant_d  = d_req & ~(if_req & streak_full);
  assign grant_if = if_req & ~grant_d;

endmodule : arb_select
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-ported memory between the fetch port (IF) and
//             the load/store port (D). One transaction outstanding at a time,
//             data has priority, fetch is guaranteed a slot after
//             MAX_DATA_STREAK consecutive data grants while it waits.
//  Ports    : clk, reset                    clock, async active-high reset
//             if_req/if_addr                fetch request (held until if_gnt)
//             if_gnt/if_rvalid/if_rdata     fetch grant and response
//             d_req/d_we/d_be/d_addr/d_wdata data request (held until d_gnt)
//             d_gnt/d_rvalid/d_rdata        data grant and response/ack
//             mem_req/we/be/addr/wdata      issue to memory
//             mem_rvalid/mem_rdata          memory response
//             spurious_rsp                  sticky: response with nothing outstanding
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W          = cpu_mem_pkg::ADDR_W,
  parameter int DATA_W          = cpu_mem_pkg::DATA_W,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  // fetch port
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  // load/store port
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  // memory side
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  // status
  output logic                  spurious_rsp
);

  import cpu_mem_pkg::*;

  localparam int              STREAK_W     = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] c_STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
  localparam logic [STREAK_W-1:0] c_STREAK_ONE = STREAK_W'(1);

  arb_state_t            r_state;
  logic                  r_owner;
  logic [STREAK_W-1:0]   r_streak;
  logic                  r_spurious;

  logic w_window;
  logic w_rsp;
  logic w_grant_if;
  logic w_grant_d;
  logic w_grant_any;

  // A new access may issue when idle, or in the cycle the outstanding one
  // completes. Everything is held quiet while reset is asserted.
  assign w_window = ~reset & ((r_state == ARB_IDLE) | mem_rvalid);
  assign w_rsp    = ~reset & (r_state == ARB_BUSY) & mem_rvalid;

  arb_select u_arb_select (
    .if_req      (if_req & w_window),
    .d_req       (d_req  & w_window),
    .streak_full (r_streak == c_STREAK_MAX),
    .grant_if    (w_grant_if),
    .grant_d     (w_grant_d)
  );

  assign w_grant_any = w_grant_if | w_grant_d;

  // FSM, owner, streak counter and sticky spurious flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ARB_IDLE;
      r_owner    <= OWNER_IF;
      r_streak   <= '0;
      r_spurious <= 1'b0;
    end else begin
      if (w_grant_any) begin
        r_state <= ARB_BUSY;
        r_owner <= w_grant_d ? OWNER_D : OWNER_IF;
      end else if (w_rsp) begin
        r_state <= ARB_IDLE;
      end

      // Streak only counts data wins that actually made fetch wait.
      if (w_grant_if || !if_req) begin
        r_streak <= '0;
      end else if (w_grant_d && (r_streak != c_STREAK_MAX)) begin
        r_streak <= r_streak + c_STREAK_ONE;
      end

      if ((r_state == ARB_IDLE) && mem_rvalid) begin
        r_spurious <= 1'b1;
      end
    end
  end

  // Grants and memory issue (driven from the winner's inputs)
  assign if_gnt    = w_grant_if;
  assign d_gnt     = w_grant_d;
  assign mem_req   = w_grant_any;
  assign mem_we    = w_grant_d & d_we;
  assign mem_be    = w_grant_d  ? d_be    :
                     w_grant_if ? {(DATA_W/8){1'b1}} : '0;
  assign mem_addr  = w_grant_d  ? d_addr  :
                     w_grant_if ? if_addr : '0;
  assign mem_wdata = (w_grant_d & d_we) ? d_wdata : '0;

  // Zero-latency response passthrough to the owner
  assign if_rvalid = w_rsp & (r_owner == OWNER_IF);
  assign d_rvalid  = w_rsp & (r_owner == OWNER_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid  ? mem_rdata : '0;

  assign spurious_rsp = r_spurious;

endmodule : mem_port_arbiter
`default_nettype wire
